// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames a serial bit stream on a start marker, assembles
// DW-bit words in a shift register and hands them downstream through a
// single output holding register with a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int DW        = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          si,
  input  logic          si_valid,
  input  logic          start,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  output logic          frame_err
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [CW-1:0]  bit_cnt;
  logic [DW-1:0]  sr;
  logic [DW-1:0]  sr_first;  // shift register image holding only bit 0
  logic [DW-1:0]  sr_next;   // shift register after accepting si

  // Bit placement: MSB-first shifts left so bit 0 ends in the MSB,
  // LSB-first shifts right so bit 0 ends in the LSB.
  always_comb begin
    sr_first = '0;
    sr_next  = sr;
    if (MSB_FIRST) begin
      sr_first = {{(DW-1){1'b0}}, si};
      sr_next  = {sr[DW-2:0], si};
    end else begin
      sr_first = {si, {(DW-1){1'b0}}};
      sr_next  = {si, sr[DW-1:1]};
    end
  end

  // Framing FSM, bit counter, shift register and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      // Downstream took the word; a completion below may reload it.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (si_valid) begin
        case (state)
          IDLE: begin
            if (start) begin
              sr      <= sr_first;
              bit_cnt <= CW'(1);
              state   <= SHIFT;
              busy    <= 1'b1;
            end
          end
          SHIFT: begin
            if (start) begin
              // Restart: partial frame is discarded, this beat is bit 0.
              frame_err <= 1'b1;
              sr        <= sr_first;
              bit_cnt   <= CW'(1);
            end else if (bit_cnt == CW'(DW-1)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
              sr      <= '0;
              // Holding register free (or draining this edge): load word.
              if (!out_valid || out_ready) begin
                out_data  <= sr_next;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              sr      <= sr_next;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
